mod_prog_tick_gen: RTL and testbench
====================================

Name: mod_prog_tick_gen

Overview:
Programmable tick generator that succeeds the fixed-modulo clock divider. It provides a runtime-programmable modulo and start phase, enable and synchronous restart, and a registered one-cycle tick. It also adds a 50%-duty divided clock and a burst mode that emits exactly N ticks and then stops. It sits between the SPI command decoder and the transfer/readout logic, which uses it for transfer_clock and readout pacing.

Parameters:
WIDTH, 26, counter and config width; all modulo/phase values are WIDTH bits.
MODULO_DEFAULT, 50000000, active modulo after reset; must satisfy 1 <= value < 2^WIDTH.
PHASE_DEFAULT, 10, counter value loaded at reset; must be < MODULO_DEFAULT.
BURST_W, 8, width of the burst length counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
en  in  1  count enable; 0 freezes the counter.
restart  in  1  synchronous restart; applies the shadow config and reloads the phase.
cfg_we  in  1  write strobe for the shadow config.
cfg_modulo  in  WIDTH  new modulo.
cfg_phase  in  WIDTH  new start phase.
burst_mode  in  1  sampled on restart; 1 selects burst, 0 selects free-run.
burst_len  in  BURST_W  number of ticks in a burst; sampled on restart.
tick  out  1  registered one-cycle pulse at each counter wrap.
div_clk  out  1  toggles at every wrap; period is 2*modulo cycles.
busy  out  1  state == RUN.
done  out  1  one-cycle pulse at the end of a burst.
cfg_err  out  1  one-cycle pulse when a config write is rejected.

Behaviour:
- Reset (rst=0, async) sets:
  - count=PHASE_DEFAULT
  - active and shadow modulo=MODULO_DEFAULT, active and shadow phase=PHASE_DEFAULT
  - state=RUN in free-run mode
  - tick=0, div_clk=0, done=0, cfg_err=0, remaining=0
  Reset in the middle of a burst abandons the burst; no done pulse is generated.
- Config write (cfg_we=1):
  - Accepted if cfg_modulo >= 1 and cfg_phase < cfg_modulo; values go to the shadow registers only.
  - Otherwise the shadow registers are unchanged and cfg_err=1 on the next cycle.
  - Shadow values never affect a running count until restart.
- Restart (restart=1), highest priority after reset; on the next edge:
  - active config <= shadow config, or <= the cfg_* inputs if cfg_we with valid values is asserted in the same cycle (write-through).
  - count <= active phase, tick <= 0, div_clk <= 0.
  - burst_mode=0: state <= RUN (free-run).
  - burst_mode=1 with burst_len>0: remaining <= burst_len, state <= RUN.
  - burst_mode=1 with burst_len=0: state <= DONE, with no ticks.
- Counting, only in RUN with en=1 and restart=0:
  - If count == modulo-1: count <= 0, tick <= 1, div_clk <= ~div_clk.
  - Else: count <= count+1, tick <= 0.
  - Outside these conditions: count holds and tick <= 0.
- Modulo = 1: count stays 0, tick is high on every enabled cycle, div_clk toggles every cycle.
- Burst accounting:
  - Each wrap decrements remaining.
  - The wrap that takes remaining from 1 to 0 issues its tick and moves state to DONE.
- DONE lasts one cycle: done=1, then state <= IDLE.
  - In IDLE, count holds, tick=0, and div_clk holds its level.
  - IDLE exits only via restart.
- Free-run never leaves RUN.
- en=0 during a burst pauses it; remaining is preserved.
- Latency: the tick is registered, so it is high in the cycle after the edge where count wraps to 0.
- Arithmetic: all comparisons are unsigned WIDTH-bit; the counter cannot exceed modulo-1 because a phase >= modulo is rejected at write time.

Test Plan:
- Power-up default with MODULO_DEFAULT=16, PHASE_DEFAULT=10, en=1, release rst -> first tick on the 6th rising edge after release; subsequent ticks every 16 cycles; div_clk period 32 cycles.
- Reprogram: cfg_we with modulo=5, phase=0, then restart -> ticks every 5 cycles, first tick 5 cycles after restart; cfg_we without restart -> the old period continues.
- Invalid config: cfg_we with modulo=0, and separately with modulo=8, phase=8 -> cfg_err pulses for 1 cycle; period unchanged after a following restart.
- Burst: restart with burst_mode=1, burst_len=3, modulo=4 -> exactly 3 ticks; done pulse in the cycle after the 3rd tick; busy falls; no further ticks for 100 cycles.
- Pause and boundaries: during that burst, en=0 for 20 cycles -> count frozen, still 3 ticks in total. Separately, burst_len=0 -> done next cycle, zero ticks. Separately, modulo=1 -> tick held high while en=1.
- Async reset asserted mid-burst between clock edges -> outputs clear immediately; after release, free-run resumes with default timing and no done pulse.

Source files
------------

// File: rtl/mod_prog_tick_gen.sv
// Programmable tick generator: runtime modulo/phase via shadow config, registered tick,
// 50% divided clock, and a burst mode that emits a fixed number of ticks then stops.
module mod_prog_tick_gen #(
    parameter int          WIDTH          = 26,
    parameter int unsigned MODULO_DEFAULT = 50000000,
    parameter int unsigned PHASE_DEFAULT  = 10,
    parameter int          BURST_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    input  logic               cfg_we,
    input  logic [WIDTH-1:0]   cfg_modulo,
    input  logic [WIDTH-1:0]   cfg_phase,
    input  logic               burst_mode,
    input  logic [BURST_W-1:0] burst_len,
    output logic               tick,
    output logic               div_clk,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [WIDTH-1:0] MOD_RST   = WIDTH'(MODULO_DEFAULT);
    localparam logic [WIDTH-1:0] PHASE_RST = WIDTH'(PHASE_DEFAULT);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        IDLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mod_q, mod_d;
    logic [WIDTH-1:0]   phase_q, phase_d;
    logic [WIDTH-1:0]   sh_mod_q, sh_phase_q;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               burst_q, burst_d;
    logic               tick_q, tick_d;
    logic               div_q, div_d;
    logic               done_q, done_d;
    logic               cfg_err_q;

    logic               cfg_valid;
    logic               wr_ok;
    logic [WIDTH-1:0]   new_mod;
    logic [WIDTH-1:0]   new_phase;
    logic               wrap;

    assign cfg_valid = (cfg_modulo != '0) && (cfg_phase < cfg_modulo);
    assign wr_ok     = cfg_we && cfg_valid;
    // A valid write in the restart cycle is applied straight to the active config.
    assign new_mod   = wr_ok ? cfg_modulo : sh_mod_q;
    assign new_phase = wr_ok ? cfg_phase  : sh_phase_q;
    assign wrap      = (count_q == mod_q - WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_mod_q   <= MOD_RST;
            sh_phase_q <= PHASE_RST;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !cfg_valid;
            if (wr_ok) begin
                sh_mod_q   <= cfg_modulo;
                sh_phase_q <= cfg_phase;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mod_d   = mod_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        burst_d = burst_q;
        tick_d  = 1'b0;
        div_d   = div_q;
        done_d  = 1'b0;
        if (restart) begin
            mod_d   = new_mod;
            phase_d = new_phase;
            count_d = new_phase;
            div_d   = 1'b0;
            burst_d = burst_mode;
            if (!burst_mode) begin
                state_d = RUN;
            end else if (burst_len != '0) begin
                rem_d   = burst_len;
                state_d = RUN;
            end else begin
                state_d = DONE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        if (wrap) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                            div_d   = ~div_q;
                            if (burst_q) begin
                                rem_d = rem_q - BURST_W'(1);
                                if (rem_q == BURST_W'(1)) state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            count_q <= PHASE_RST;
            mod_q   <= MOD_RST;
            phase_q <= PHASE_RST;
            rem_q   <= '0;
            burst_q <= 1'b0;
            tick_q  <= 1'b0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mod_q   <= mod_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            burst_q <= burst_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    assign tick    = tick_q;
    assign div_clk = div_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mod_prog_tick_gen.sv
// Directed bench for mod_prog_tick_gen with a small default modulo (16) and phase (10).
module tb_mod_prog_tick_gen;

    localparam int WIDTH   = 26;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               restart;
    logic               cfg_we;
    logic [WIDTH-1:0]   cfg_modulo;
    logic [WIDTH-1:0]   cfg_phase;
    logic               burst_mode;
    logic [BURST_W-1:0] burst_len;
    logic               tick, div_clk, busy, done, cfg_err;

    int vectors    = 0;
    int miscompares = 0;
    int done_seen  = 0;

    mod_prog_tick_gen #(
        .WIDTH(WIDTH), .MODULO_DEFAULT(16), .PHASE_DEFAULT(10), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart), .cfg_we(cfg_we),
        .cfg_modulo(cfg_modulo), .cfg_phase(cfg_phase), .burst_mode(burst_mode),
        .burst_len(burst_len), .tick(tick), .div_clk(div_clk), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until tick is seen high, or -1 on timeout.
    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (done === 1'b1) done_seen++;
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_restart(input logic bm, input logic [BURST_W-1:0] bl,
                              input logic we, input int m, input int p);
        restart    = 1'b1;
        burst_mode = bm;
        burst_len  = bl;
        cfg_we     = we;
        cfg_modulo = WIDTH'(m);
        cfg_phase  = WIDTH'(p);
        step();
        restart = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0; en = 1'b1; restart = 1'b0; cfg_we = 1'b0;
        cfg_modulo = '0; cfg_phase = '0; burst_mode = 1'b0; burst_len = '0;
        step();
        step();
        vectors += 5;
        if (tick !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_tick got %b want 0", tick); end
        if (div_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_div got %b want 0", div_clk); end
        if (done !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cfg_err got %b want 0", cfg_err); end
        if (busy !== 1'b1)    begin miscompares++; $display("[TB] FAIL reset_busy got %b want 1", busy); end
        rst = 1'b1;
        wait_tick(40, n);
        vectors += 2;
        if (n != 6)           begin miscompares++; $display("[TB] FAIL first_tick got %0d want 6", n); end
        if (div_clk !== 1'b1) begin miscompares++; $display("[TB] FAIL div_after_tick1 got %b want 1", div_clk); end
        wait_tick(40, n);
        vectors += 2;
        if (n != 16)          begin miscompares++; $display("[TB] FAIL second_tick got %0d want 16", n); end
        if (div_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL div_after_tick2 got %b want 0", div_clk); end
        step();
        vectors++;
        if (tick !== 1'b0)    begin miscompares++; $display("[TB] FAIL tick_width got %b want 0", tick); end
    endtask

    task automatic test_reprogram();
        int n;
        wait_tick(40, n);
        vectors++;
        if (n != 15) begin miscompares++; $display("[TB] FAIL pre_write_tick got %0d want 15", n); end
        cfg_we = 1'b1; cfg_modulo = WIDTH'(5); cfg_phase = WIDTH'(0);
        step();
        cfg_we = 1'b0;
        vectors++;
        if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL valid_write_err got %b want 0", cfg_err); end
        wait_tick(40, n);
        vectors++;
        if (n != 15) begin miscompares++; $display("[TB] FAIL shadow_isolated got %0d want 15", n); end
        do_restart(1'b0, '0, 1'b0, 0, 0);
        vectors += 2;
        if (tick !== 1'b0)    begin miscompares++; $display("[TB] FAIL restart_tick got %b want 0", tick); end
        if (div_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_div got %b want 0", div_clk); end
        wait_tick(40, n);
        vectors++;
        if (n != 5) begin miscompares++; $display("[TB] FAIL reprog_first got %0d want 5", n); end
        wait_tick(40, n);
        vectors++;
        if (n != 5) begin miscompares++; $display("[TB] FAIL reprog_period got %0d want 5", n); end
    endtask

    task automatic test_invalid_cfg();
        int n;
        cfg_we = 1'b1; cfg_modulo = WIDTH'(0); cfg_phase = WIDTH'(0);
        step();
        cfg_we = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_mod0 got %b want 1", cfg_err); end
        step();
        vectors++;
        if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_mod0_pulse got %b want 0", cfg_err); end
        cfg_we = 1'b1; cfg_modulo = WIDTH'(8); cfg_phase = WIDTH'(8);
        step();
        cfg_we = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_phase got %b want 1", cfg_err); end
        step();
        vectors++;
        if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_phase_pulse got %b want 0", cfg_err); end
        do_restart(1'b0, '0, 1'b0, 0, 0);
        wait_tick(40, n);
        vectors++;
        if (n != 5) begin miscompares++; $display("[TB] FAIL invalid_kept_period got %0d want 5", n); end
    endtask

    task automatic test_burst();
        int ticks = 0, dones = 0, last_tick = -1, done_at = -1;
        do_restart(1'b1, 8'd3, 1'b1, 4, 0);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_busy got %b want 1", busy); end
        for (int c = 1; c <= 120; c++) begin
            step();
            if (tick === 1'b1) begin ticks++; last_tick = c; end
            if (done === 1'b1) begin dones++; done_at = c; end
        end
        vectors += 5;
        if (ticks != 3)     begin miscompares++; $display("[TB] FAIL burst_ticks got %0d want 3", ticks); end
        if (last_tick != 12) begin miscompares++; $display("[TB] FAIL burst_last got %0d want 12", last_tick); end
        if (dones != 1)     begin miscompares++; $display("[TB] FAIL burst_dones got %0d want 1", dones); end
        if (done_at != 13)  begin miscompares++; $display("[TB] FAIL burst_done_at got %0d want 13", done_at); end
        if (busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL burst_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_pause();
        int ticks = 0, pause_ticks = 0, first = -1, done_at = -1;
        do_restart(1'b1, 8'd3, 1'b0, 0, 0);
        step();
        step();
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (tick === 1'b1) pause_ticks++;
        end
        vectors += 2;
        if (pause_ticks != 0) begin miscompares++; $display("[TB] FAIL pause_ticks got %0d want 0", pause_ticks); end
        if (busy !== 1'b1)    begin miscompares++; $display("[TB] FAIL pause_busy got %b want 1", busy); end
        en = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            step();
            if (tick === 1'b1) begin ticks++; if (first < 0) first = c; end
            if (done === 1'b1) done_at = c;
        end
        vectors += 3;
        if (first != 2)    begin miscompares++; $display("[TB] FAIL pause_resume got %0d want 2", first); end
        if (ticks != 3)    begin miscompares++; $display("[TB] FAIL pause_total got %0d want 3", ticks); end
        if (done_at != 11) begin miscompares++; $display("[TB] FAIL pause_done_at got %0d want 11", done_at); end
    endtask

    task automatic test_burst_zero();
        int ticks = 0;
        do_restart(1'b1, 8'd0, 1'b0, 0, 0);
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy got %b want 0", busy); end
        if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_tick got %b want 0", tick); end
        step();
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done got %b want 1", done); end
        step();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_pulse got %b want 0", done); end
        for (int c = 0; c < 20; c++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 0) begin miscompares++; $display("[TB] FAIL zero_ticks got %0d want 0", ticks); end
    endtask

    task automatic test_modulo_one();
        logic prev;
        do_restart(1'b0, '0, 1'b1, 1, 0);
        prev = div_clk;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors += 2;
            if (tick !== 1'b1)    begin miscompares++; $display("[TB] FAIL mod1_tick[%0d] got %b want 1", c, tick); end
            if (div_clk !== ~prev) begin miscompares++; $display("[TB] FAIL mod1_div[%0d] got %b want %b", c, div_clk, ~prev); end
            prev = div_clk;
        end
        en = 1'b0;
        step();
        vectors++;
        if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL mod1_en_off got %b want 0", tick); end
        en = 1'b1;
    endtask

    task automatic test_async_reset_mid_burst();
        int n;
        do_restart(1'b1, 8'd3, 1'b1, 4, 0);
        for (int c = 0; c < 4; c++) step();
        vectors++;
        if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_tick got %b want 1", tick); end
        #2;
        rst = 1'b0;
        #1;
        vectors += 3;
        if (tick !== 1'b0)    begin miscompares++; $display("[TB] FAIL async_tick got %b want 0", tick); end
        if (div_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL async_div got %b want 0", div_clk); end
        if (busy !== 1'b1)    begin miscompares++; $display("[TB] FAIL async_busy got %b want 1", busy); end
        step();
        rst = 1'b1;
        done_seen = 0;
        wait_tick(40, n);
        vectors++;
        if (n != 6)  begin miscompares++; $display("[TB] FAIL post_reset_first got %0d want 6", n); end
        wait_tick(40, n);
        vectors += 2;
        if (n != 16) begin miscompares++; $display("[TB] FAIL post_reset_period got %0d want 16", n); end
        if (done_seen != 0) begin miscompares++; $display("[TB] FAIL post_reset_done got %0d want 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_reprogram();
        test_invalid_cfg();
        test_burst();
        test_pause();
        test_burst_zero();
        test_modulo_one();
        test_async_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
